// File: rtl/cgra_rf_pkg.sv
// Shared register-file parameters used by the write arbiter and the register file.
package cgra_rf_pkg;

  localparam int unsigned LOG2REGS = 3;
  localparam int unsigned SIZE     = 32;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned PTR_W    = 2;

  // Round-robin successor of a channel index (wraps modulo NREQ).
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
    return idx + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rf_req_fifo.sv
// Two-entry request FIFO holding {address, data} write requests for one producer.
module rf_req_fifo #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
) (
  input  logic          CGRA_Clock,
  input  logic          CGRA_Reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);

  localparam int unsigned EW = AW + DW;

  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          do_push, do_pop;

  // Guarded push/pop, pointer and occupancy update.
  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {push_addr, push_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset empties the FIFO.
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full                   = (count_q == 2'd2);
  assign empty                  = (count_q == 2'd0);
  assign {head_addr, head_data} = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges four producer write streams onto the two write ports of the register file,
// round-robin, never issuing two same-cycle writes to one address.
module regfile_write_arbiter
  import cgra_rf_pkg::*;
#(
  parameter int unsigned log2regs = cgra_rf_pkg::LOG2REGS,
  parameter int unsigned size     = cgra_rf_pkg::SIZE,
  parameter int unsigned NREQ     = cgra_rf_pkg::NREQ
) (
  input  logic                CGRA_Clock,
  input  logic                CGRA_Reset,
  input  logic                req_valid0,
  input  logic                req_valid1,
  input  logic                req_valid2,
  input  logic                req_valid3,
  input  logic [log2regs-1:0] req_addr0,
  input  logic [log2regs-1:0] req_addr1,
  input  logic [log2regs-1:0] req_addr2,
  input  logic [log2regs-1:0] req_addr3,
  input  logic [size-1:0]     req_data0,
  input  logic [size-1:0]     req_data1,
  input  logic [size-1:0]     req_data2,
  input  logic [size-1:0]     req_data3,
  output logic                req_ready0,
  output logic                req_ready1,
  output logic                req_ready2,
  output logic                req_ready3,
  output logic                WE0,
  output logic                WE1,
  output logic [log2regs-1:0] address_in0,
  output logic [log2regs-1:0] address_in1,
  output logic [size-1:0]     in0,
  output logic [size-1:0]     in1,
  output logic                busy
);

  logic [NREQ-1:0]     valid_w, push_w, pop_w, full_w, empty_w;
  logic [log2regs-1:0] req_addr_w  [NREQ];
  logic [size-1:0]     req_data_w  [NREQ];
  logic [log2regs-1:0] head_addr_w [NREQ];
  logic [size-1:0]     head_data_w [NREQ];

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we0_q, we0_d, we1_q, we1_d;
  logic [log2regs-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [size-1:0]     data0_q, data0_d, data1_q, data1_d;

  logic                g0_found, g1_found;
  logic [PTR_W-1:0]    g0_idx, g1_idx, cand_idx;

  assign valid_w       = {req_valid3, req_valid2, req_valid1, req_valid0};
  assign req_addr_w[0] = req_addr0;
  assign req_addr_w[1] = req_addr1;
  assign req_addr_w[2] = req_addr2;
  assign req_addr_w[3] = req_addr3;
  assign req_data_w[0] = req_data0;
  assign req_data_w[1] = req_data1;
  assign req_data_w[2] = req_data2;
  assign req_data_w[3] = req_data3;

  // Ready depends only on FIFO occupancy, never on the valid inputs.
  assign push_w = valid_w & ~full_w;

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    rf_req_fifo #(
      .AW(log2regs),
      .DW(size)
    ) u_fifo (
      .CGRA_Clock(CGRA_Clock),
      .CGRA_Reset(CGRA_Reset),
      .push      (push_w[g]),
      .push_addr (req_addr_w[g]),
      .push_data (req_data_w[g]),
      .pop       (pop_w[g]),
      .full      (full_w[g]),
      .empty     (empty_w[g]),
      .head_addr (head_addr_w[g]),
      .head_data (head_data_w[g])
    );
  end

  // Round-robin scan: first non-empty channel to port 0, second to port 1 unless
  // its head targets the same register, in which case it waits a cycle.
  always_comb begin
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    cand_idx = '0;
    pop_w    = '0;
    we0_d    = 1'b0;
    we1_d    = 1'b0;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    rr_ptr_d = rr_ptr_q;

    for (int k = 0; k < NREQ; k++) begin
      cand_idx = rr_ptr_q + PTR_W'(k);
      if (!empty_w[cand_idx]) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = cand_idx;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = cand_idx;
        end
      end
    end

    if (g0_found) begin
      we0_d         = 1'b1;
      addr0_d       = head_addr_w[g0_idx];
      data0_d       = head_data_w[g0_idx];
      pop_w[g0_idx] = 1'b1;
      rr_ptr_d      = rr_next(g0_idx);
      if (g1_found && (head_addr_w[g1_idx] != head_addr_w[g0_idx])) begin
        we1_d         = 1'b1;
        addr1_d       = head_addr_w[g1_idx];
        data1_d       = head_data_w[g1_idx];
        pop_w[g1_idx] = 1'b1;
        rr_ptr_d      = rr_next(g1_idx);
      end
    end
  end

  // Pointer and write-port registers; reset drops any pending issue.
  always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
    if (CGRA_Reset) begin
      rr_ptr_q <= '0;
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we0_q    <= we0_d;
      we1_q    <= we1_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign WE0         = we0_q;
  assign WE1         = we1_q;
  assign address_in0 = addr0_q;
  assign address_in1 = addr1_q;
  assign in0         = data0_q;
  assign in1         = data1_q;
  assign req_ready0  = ~full_w[0];
  assign req_ready1  = ~full_w[1];
  assign req_ready2  = ~full_w[2];
  assign req_ready3  = ~full_w[3];
  assign busy        = (|(~empty_w)) | we0_q | we1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus multi-cycle sequences.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  vld = 4'b0;
  logic [2:0]  ad [4];
  logic [31:0] dt [4];
  logic [3:0]  rdy;
  logic        we0, we1, busy;
  logic [2:0]  a0, a1;
  logic [31:0] d0, d1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .CGRA_Clock (clk),
    .CGRA_Reset (rst),
    .req_valid0 (vld[0]), .req_valid1(vld[1]), .req_valid2(vld[2]), .req_valid3(vld[3]),
    .req_addr0  (ad[0]),  .req_addr1 (ad[1]),  .req_addr2 (ad[2]),  .req_addr3 (ad[3]),
    .req_data0  (dt[0]),  .req_data1 (dt[1]),  .req_data2 (dt[2]),  .req_data3 (dt[3]),
    .req_ready0 (rdy[0]), .req_ready1(rdy[1]), .req_ready2(rdy[2]), .req_ready3(rdy[3]),
    .WE0        (we0),
    .WE1        (we1),
    .address_in0(a0),
    .address_in1(a1),
    .in0        (d0),
    .in1        (d1),
    .busy       (busy)
  );

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][2:0]  a;
    logic [3:0][31:0] d;
    logic             ew0;
    logic [2:0]       ea0;
    logic [31:0]      ed0;
    logic             ew1;
    logic [2:0]       ea1;
    logic [31:0]      ed1;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and check the port-conflict invariant.
  task automatic tick();
    @(posedge clk);
    #1;
    n_tests++;
    if (we0 && we1 && (a0 == a1)) begin
      n_fail++;
      $display("FAIL dual_same_addr: WE0=WE1=1 on address %0d", a0);
    end
  endtask

  task automatic chk_out(input string tag, input logic ew0, input logic [2:0] ea0,
                         input logic [31:0] ed0, input logic ew1, input logic [2:0] ea1,
                         input logic [31:0] ed1);
    chk({tag, ".WE0"}, 32'(we0), 32'(ew0));
    chk({tag, ".addr0"}, 32'(a0), 32'(ea0));
    chk({tag, ".in0"}, d0, ed0);
    chk({tag, ".WE1"}, 32'(we1), 32'(ew1));
    chk({tag, ".addr1"}, 32'(a1), 32'(ea1));
    chk({tag, ".in1"}, d1, ed1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 4'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int gcount [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      ad[i] = '0;
      dt[i] = '0;
    end

    vecs[0] = '{v: 4'b0001, a: {3'd0, 3'd0, 3'd0, 3'd5}, d: {32'd0, 32'd0, 32'd0, 32'hDEADBEEF},
                ew0: 1'b1, ea0: 3'd5, ed0: 32'hDEADBEEF, ew1: 1'b0, ea1: 3'd0, ed1: 32'd0};
    vecs[1] = '{v: 4'b1010, a: {3'd6, 3'd0, 3'd2, 3'd0}, d: {32'h33, 32'd0, 32'h11, 32'd0},
                ew0: 1'b1, ea0: 3'd2, ed0: 32'h11, ew1: 1'b1, ea1: 3'd6, ed1: 32'h33};
    vecs[2] = '{v: 4'b0011, a: {3'd0, 3'd0, 3'd4, 3'd4}, d: {32'd0, 32'd0, 32'hA1, 32'hA0},
                ew0: 1'b1, ea0: 3'd4, ed0: 32'hA0, ew1: 1'b0, ea1: 3'd0, ed1: 32'd0};
    vecs[3] = '{v: 4'b0100, a: {3'd0, 3'd1, 3'd0, 3'd0}, d: {32'd0, 32'h22, 32'd0, 32'd0},
                ew0: 1'b1, ea0: 3'd1, ed0: 32'h22, ew1: 1'b0, ea1: 3'd0, ed1: 32'd0};
    vecs[4] = '{v: 4'b1111, a: {3'd3, 3'd2, 3'd1, 3'd0}, d: {32'd103, 32'd102, 32'd101, 32'd100},
                ew0: 1'b1, ea0: 3'd0, ed0: 32'd100, ew1: 1'b1, ea1: 3'd1, ed1: 32'd101};
    vecs[5] = '{v: 4'b1001, a: {3'd7, 3'd0, 3'd0, 3'd7}, d: {32'h73, 32'd0, 32'd0, 32'h70},
                ew0: 1'b1, ea0: 3'd7, ed0: 32'h70, ew1: 1'b0, ea1: 3'd0, ed1: 32'd0};
    vecs[6] = '{v: 4'b1100, a: {3'd4, 3'd3, 3'd0, 3'd0}, d: {32'h6, 32'h5, 32'd0, 32'd0},
                ew0: 1'b1, ea0: 3'd3, ed0: 32'h5, ew1: 1'b1, ea1: 3'd4, ed1: 32'h6};

    // Values while reset is held.
    tick();
    chk_out("reset", 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    chk("reset.ready", 32'(rdy), 32'hF);
    chk("reset.busy", 32'(busy), 32'd0);

    // Table: one-edge presentation after reset, first issue checked one edge after accept.
    for (int n = 0; n < NVEC; n++) begin
      do_reset();
      vld = vecs[n].v;
      for (int i = 0; i < 4; i++) begin
        ad[i] = vecs[n].a[i];
        dt[i] = vecs[n].d[i];
      end
      tick();
      chk($sformatf("vec%0d.busy_q", n), 32'(busy), 32'd1);
      vld = 4'b0;
      tick();
      chk_out($sformatf("vec%0d", n), vecs[n].ew0, vecs[n].ea0, vecs[n].ed0,
              vecs[n].ew1, vecs[n].ea1, vecs[n].ed1);
      for (int t = 0; t < 4; t++) tick();
      chk($sformatf("vec%0d.busy_idle", n), 32'(busy), 32'd0);
    end

    // Single write: latency, then WE drops while address/data hold.
    do_reset();
    vld = 4'b0001; ad[0] = 3'd5; dt[0] = 32'hDEADBEEF;
    tick();
    vld = 4'b0;
    chk("single.WE0_early", 32'(we0), 32'd0);
    tick();
    chk_out("single", 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    tick();
    chk_out("single.hold", 1'b0, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    chk("single.busy", 32'(busy), 32'd0);

    // Collision: ch0 issues first, ch1 follows on port 0 next cycle.
    do_reset();
    vld = 4'b0011; ad[0] = 3'd4; ad[1] = 3'd4; dt[0] = 32'hA0; dt[1] = 32'hA1;
    tick();
    vld = 4'b0;
    tick();
    chk_out("coll.c1", 1'b1, 3'd4, 32'hA0, 1'b0, 3'd0, 32'd0);
    tick();
    chk_out("coll.c2", 1'b1, 3'd4, 32'hA1, 1'b0, 3'd0, 32'd0);
    tick();
    chk("coll.WE0_off", 32'(we0), 32'd0);
    chk("coll.busy", 32'(busy), 32'd0);

    // Fairness: all channels valid continuously; pairs 0,1 / 2,3 / 0,1 / 2,3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      gcount[i] = 0;
      ad[i] = 3'(i);
      dt[i] = 32'(100 + i);
    end
    vld = 4'b1111;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("fair%0d.WE0", c), 32'(we0), 32'd1);
      chk($sformatf("fair%0d.addr0", c), 32'(a0), (c % 2 == 0) ? 32'd0 : 32'd2);
      chk($sformatf("fair%0d.WE1", c), 32'(we1), 32'd1);
      chk($sformatf("fair%0d.addr1", c), 32'(a1), (c % 2 == 0) ? 32'd1 : 32'd3);
      if (we0) gcount[a0[1:0]]++;
      if (we1) gcount[a1[1:0]]++;
    end
    vld = 4'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("fair.count%0d", i), 32'(gcount[i]), 32'd2);
    for (int t = 0; t < 6; t++) tick();
    chk("fair.busy", 32'(busy), 32'd0);

    // Backpressure on ch2 while ch0/ch1 take the first grants.
    do_reset();
    vld = 4'b0111;
    ad[0] = 3'd0; dt[0] = 32'hC0;
    ad[1] = 3'd1; dt[1] = 32'hC1;
    ad[2] = 3'd5; dt[2] = 32'hB0A;
    tick();
    chk("bp.e1.ready2", 32'(rdy[2]), 32'd1);
    vld = 4'b0100; ad[2] = 3'd6; dt[2] = 32'hB0B;
    tick();
    chk("bp.e2.ready2", 32'(rdy[2]), 32'd0);
    chk_out("bp.e2", 1'b1, 3'd0, 32'hC0, 1'b1, 3'd1, 32'hC1);
    ad[2] = 3'd7; dt[2] = 32'hB0C;
    tick();
    chk_out("bp.e3", 1'b1, 3'd5, 32'hB0A, 1'b0, 3'd1, 32'hC1);
    chk("bp.e3.ready2", 32'(rdy[2]), 32'd1);
    tick();
    vld = 4'b0;
    chk_out("bp.e4", 1'b1, 3'd6, 32'hB0B, 1'b0, 3'd1, 32'hC1);
    tick();
    chk_out("bp.e5", 1'b1, 3'd7, 32'hB0C, 1'b0, 3'd1, 32'hC1);
    tick();
    chk("bp.e6.WE0", 32'(we0), 32'd0);
    chk("bp.e6.busy", 32'(busy), 32'd0);

    // Reset mid-operation: queued writes vanish without a WE pulse.
    vld = 4'b0011; ad[0] = 3'd3; dt[0] = 32'h55; ad[1] = 3'd2; dt[1] = 32'h66;
    tick();
    vld = 4'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("rmid", 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    chk("rmid.ready", 32'(rdy), 32'hF);
    chk("rmid.busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("rmid.after%0d.WE", t), 32'({we0, we1}), 32'd0);
      chk($sformatf("rmid.after%0d.busy", t), 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
